// File: rtl/trigger_out_pkg.sv
// rtl/trigger_out_pkg.sv - shared state encoding and defaults for the trigger output generator
package trigger_out_pkg;

  localparam int DEFAULT_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_DELAY   = 3'd2,
    ST_PULSE   = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_e;

  function automatic logic state_is_busy(input logic [2:0] s);
    return (s == ST_DELAY) || (s == ST_PULSE) || (s == ST_HOLDOFF);
  endfunction

endpackage

// File: rtl/trigger_out_gen_if.sv
// rtl/trigger_out_gen_if.sv - control and status bundle between host logic and trigger_out_gen
interface trigger_out_gen_if
  import trigger_out_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
);

  logic             I_trigger;
  logic             I_arm;
  logic             I_disarm;
  logic             I_oneshot;
  logic             I_polarity;
  logic [CNT_W-1:0] I_delay;
  logic [CNT_W-1:0] I_width;
  logic [CNT_W-1:0] I_holdoff;
  logic             I_count_clear;
  logic             O_trig_out;
  logic             O_armed;
  logic             O_busy;
  logic [CNT_W-1:0] O_pulse_count;

  modport master (
    output I_trigger, I_arm, I_disarm, I_oneshot, I_polarity,
    output I_delay, I_width, I_holdoff, I_count_clear,
    input  O_trig_out, O_armed, O_busy, O_pulse_count
  );

  modport slave (
    input  I_trigger, I_arm, I_disarm, I_oneshot, I_polarity,
    input  I_delay, I_width, I_holdoff, I_count_clear,
    output O_trig_out, O_armed, O_busy, O_pulse_count
  );

endinterface

// File: rtl/trigger_edge_detect.sv
// rtl/trigger_edge_detect.sv - rising-edge detector for the selected trigger input
module trigger_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic trig_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      trig_r <= 1'b0;
    end else begin
      trig_r <= in;
    end
  end

  assign rise = in & ~trig_r;

endmodule

// File: rtl/trigger_out_gen.sv
// rtl/trigger_out_gen.sv - armed delay/width/holdoff trigger pulse generator; TRIGGER_OUT_COUNTER_EN adds the pulse counter
module trigger_out_gen
  import trigger_out_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input logic              clk,
  input logic              reset,
  trigger_out_gen_if.slave bus
);

  localparam logic [2:0] IDLE    = ST_IDLE;
  localparam logic [2:0] ARMED   = ST_ARMED;
  localparam logic [2:0] DELAY   = ST_DELAY;
  localparam logic [2:0] PULSE   = ST_PULSE;
  localparam logic [2:0] HOLDOFF = ST_HOLDOFF;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       state;
  logic [2:0]       state_nx;
  logic [2:0]       finish_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic [CNT_W-1:0] width_q;
  logic [CNT_W-1:0] width_nx;
  logic [CNT_W-1:0] holdoff_q;
  logic [CNT_W-1:0] holdoff_nx;
  logic             rise;
  logic             trig_out_q;
  logic             pulse_entry;

  // Pulse counter holds remaining cycles minus one; a zero width still gives one cycle.
  function automatic logic [CNT_W-1:0] pulse_load(input logic [CNT_W-1:0] w);
    return (w == '0) ? '0 : (w - ONE);
  endfunction

  trigger_edge_detect u_edge (
    .clk  (clk),
    .reset(reset),
    .in   (bus.I_trigger),
    .rise (rise)
  );

  assign finish_state = bus.I_oneshot ? IDLE : ARMED;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    width_nx   = width_q;
    holdoff_nx = holdoff_q;
    if (bus.I_disarm) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.I_arm) begin
            state_nx = ARMED;
          end
        end
        ARMED: begin
          if (rise) begin
            width_nx   = bus.I_width;
            holdoff_nx = bus.I_holdoff;
            if (bus.I_delay != '0) begin
              state_nx = DELAY;
              cnt_nx   = bus.I_delay - ONE;
            end else begin
              state_nx = PULSE;
              cnt_nx   = pulse_load(bus.I_width);
            end
          end
        end
        DELAY: begin
          if (cnt == '0) begin
            state_nx = PULSE;
            cnt_nx   = pulse_load(width_q);
          end else begin
            cnt_nx = cnt - ONE;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            if (holdoff_q != '0) begin
              state_nx = HOLDOFF;
              cnt_nx   = holdoff_q - ONE;
            end else begin
              state_nx = finish_state;
            end
          end else begin
            cnt_nx = cnt - ONE;
          end
        end
        HOLDOFF: begin
          if (cnt == '0) begin
            state_nx = finish_state;
          end else begin
            cnt_nx = cnt - ONE;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  assign pulse_entry = (state_nx == PULSE) && (state != PULSE);

  // Output level is registered with polarity applied so the pin never sees a combinational glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      width_q    <= '0;
      holdoff_q  <= '0;
      trig_out_q <= bus.I_polarity;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      width_q    <= width_nx;
      holdoff_q  <= holdoff_nx;
      trig_out_q <= ((state == PULSE) && !bus.I_disarm) ^ bus.I_polarity;
    end
  end

  assign bus.O_trig_out = trig_out_q;
  assign bus.O_armed    = (state == ARMED);
  assign bus.O_busy     = state_is_busy(state);

`ifdef TRIGGER_OUT_COUNTER_EN
  logic [CNT_W-1:0] pulse_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      pulse_count <= '0;
    end else if (bus.I_count_clear) begin
      pulse_count <= '0;
    end else if (pulse_entry && (pulse_count != '1)) begin
      pulse_count <= pulse_count + ONE;
    end
  end

  assign bus.O_pulse_count = pulse_count;
`else
  logic unused_count_inputs;
  assign unused_count_inputs = bus.I_count_clear ^ pulse_entry;
  assign bus.O_pulse_count   = '0;
`endif

endmodule

// File: tb/tb_trigger_out_gen.sv
// tb/tb_trigger_out_gen.sv - scoreboard bench for trigger_out_gen against a timeline reference model
module tb_trigger_out_gen;

  localparam int W = 8;
  localparam logic [W-1:0] CNT_MAX = '1;
`ifdef TRIGGER_OUT_COUNTER_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  trigger_out_gen_if #(.CNT_W(W)) bus ();

  trigger_out_gen #(.CNT_W(W)) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bus)
  );

  typedef struct {
    logic         trig;
    logic         armed;
    logic         busy;
    logic [W-1:0] count;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act === want) passes++;
    else $display("FAIL %s: got %0h expected %0h at time %0t", name, act, want, $time);
  endtask

  // Reference model: each accepted edge at cycle acc defines a fixed timeline
  // (pulse after cycles acc+d+1 .. acc+d+wl, busy until acc+d+wl+h).
  int           m_t = 0;
  int           m_acc = 0;
  int           m_d = 0;
  int           m_wl = 1;
  int           m_h = 0;
  bit           m_armed = 1'b0;
  bit           m_inflight = 1'b0;
  bit           m_prev = 1'b0;
  bit           m_rise;
  bit           m_active;
  logic [W-1:0] m_count = '0;

  initial begin : model
    exp_t e;
    forever begin
      @(posedge clk);
      m_t++;
      if (rst) begin
        m_armed    = 1'b0;
        m_inflight = 1'b0;
        m_prev     = 1'b0;
        m_count    = '0;
        e.trig     = bus.I_polarity;
      end else begin
        m_rise   = bus.I_trigger && !m_prev;
        m_prev   = bus.I_trigger;
        m_active = m_inflight && (m_t >= m_acc + m_d + 1) && (m_t <= m_acc + m_d + m_wl) && !bus.I_disarm;
        if (bus.I_disarm) begin
          m_armed    = 1'b0;
          m_inflight = 1'b0;
        end else if (m_inflight) begin
          if (m_t == m_acc + m_d + m_wl + m_h) begin
            m_inflight = 1'b0;
            m_armed    = !bus.I_oneshot;
          end
        end else if (m_armed) begin
          if (m_rise) begin
            m_inflight = 1'b1;
            m_armed    = 1'b0;
            m_acc      = m_t;
            m_d        = int'(bus.I_delay);
            m_wl       = (bus.I_width == '0) ? 1 : int'(bus.I_width);
            m_h        = int'(bus.I_holdoff);
          end
        end else if (bus.I_arm) begin
          m_armed = 1'b1;
        end
        if (COUNT_EN) begin
          if (bus.I_count_clear) m_count = '0;
          else if (m_inflight && (m_t == m_acc + m_d) && (m_count != CNT_MAX)) m_count = m_count + 1'b1;
        end
        e.trig = m_active ^ bus.I_polarity;
      end
      e.armed = m_armed;
      e.busy  = m_inflight;
      e.count = m_count;
      sb_q.push_back(e);
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sb_trig_out", {31'd0, bus.O_trig_out}, {31'd0, e.trig});
        check("sb_armed", {31'd0, bus.O_armed}, {31'd0, e.armed});
        check("sb_busy", {31'd0, bus.O_busy}, {31'd0, e.busy});
        check("sb_pulse_count", {24'd0, bus.O_pulse_count}, {24'd0, e.count});
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.I_arm         = 1'b0;
      bus.I_disarm      = 1'b0;
      bus.I_count_clear = 1'b0;
    end
  endtask

  task automatic setup(input int d, input int wd, input int h, input bit os, input bit pol);
    bus.I_delay    = W'(d);
    bus.I_width    = W'(wd);
    bus.I_holdoff  = W'(h);
    bus.I_oneshot  = os;
    bus.I_polarity = pol;
  endtask

  initial begin : stim
    logic [5:0] want41;
    rst = 1'b1;
    bus.I_trigger = 1'b0;
    bus.I_arm = 1'b0;
    bus.I_disarm = 1'b0;
    bus.I_count_clear = 1'b0;
    setup(0, 0, 0, 1'b1, 1'b0);
    tick(3);
    check("reset_trig_out", {31'd0, bus.O_trig_out}, 32'd0);
    check("reset_busy", {31'd0, bus.O_busy}, 32'd0);
    rst = 1'b0;

    // Delay 3, width 2: pulse visible after the 4th and 5th edges past the trigger edge.
    setup(3, 2, 0, 1'b1, 1'b0);
    bus.I_arm = 1'b1;
    tick(2);
    bus.I_trigger = 1'b1;
    tick(1);
    want41 = 6'b011000;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      check("delay3_trig_out", {31'd0, bus.O_trig_out}, {31'd0, want41[k-1]});
    end
    check("delay3_armed", {31'd0, bus.O_armed}, 32'd0);
    check("delay3_busy", {31'd0, bus.O_busy}, 32'd0);
    check("delay3_count", {24'd0, bus.O_pulse_count}, COUNT_EN ? 32'd1 : 32'd0);
    bus.I_trigger = 1'b0;

    // Delay 0, width 0: single-cycle pulse right after the trigger edge.
    setup(0, 0, 0, 1'b1, 1'b0);
    bus.I_arm = 1'b1;
    tick(2);
    bus.I_trigger = 1'b1;
    tick(2);
    check("width0_on", {31'd0, bus.O_trig_out}, 32'd1);
    tick(1);
    check("width0_off", {31'd0, bus.O_trig_out}, 32'd0);
    bus.I_trigger = 1'b0;

    // Auto re-arm with holdoff while the trigger keeps toggling.
    setup(1, 2, 5, 1'b0, 1'b0);
    bus.I_arm = 1'b1;
    tick(1);
    for (int i = 0; i < 30; i++) begin
      bus.I_trigger = ~bus.I_trigger;
      tick(2);
    end
    bus.I_disarm = 1'b1;
    bus.I_trigger = 1'b0;
    tick(2);

    // Disarm during DELAY, then during PULSE.
    setup(6, 2, 0, 1'b1, 1'b0);
    bus.I_arm = 1'b1;
    tick(2);
    bus.I_trigger = 1'b1;
    tick(3);
    bus.I_disarm = 1'b1;
    tick(1);
    check("disarm_delay_busy", {31'd0, bus.O_busy}, 32'd0);
    check("disarm_delay_armed", {31'd0, bus.O_armed}, 32'd0);
    tick(10);
    setup(0, 6, 0, 1'b1, 1'b0);
    bus.I_trigger = 1'b0;
    bus.I_arm = 1'b1;
    tick(2);
    bus.I_trigger = 1'b1;
    tick(3);
    bus.I_disarm = 1'b1;
    tick(1);
    check("disarm_pulse_trig_out", {31'd0, bus.O_trig_out}, 32'd0);
    tick(8);

    // Width changed while the pulse is still in its delay.
    setup(4, 2, 0, 1'b1, 1'b0);
    bus.I_trigger = 1'b0;
    bus.I_arm = 1'b1;
    tick(2);
    bus.I_trigger = 1'b1;
    tick(2);
    bus.I_width = W'(7);
    tick(12);

    // Active-low output with reset landing mid-pulse.
    setup(0, 6, 0, 1'b1, 1'b1);
    bus.I_trigger = 1'b0;
    bus.I_arm = 1'b1;
    tick(2);
    bus.I_trigger = 1'b1;
    tick(3);
    check("pol1_pulse_low", {31'd0, bus.O_trig_out}, 32'd0);
    rst = 1'b1;
    tick(1);
    check("pol1_reset_high", {31'd0, bus.O_trig_out}, 32'd1);
    rst = 1'b0;
    tick(2);

    // Back-to-back pulses to saturate the counter, with clears landing on pulse entries.
    setup(0, 1, 0, 1'b0, 1'b0);
    bus.I_trigger = 1'b0;
    bus.I_arm = 1'b1;
    tick(1);
    for (int i = 0; i < 600; i++) begin
      bus.I_trigger = ~bus.I_trigger;
      if (i == 560 || i == 561) bus.I_count_clear = 1'b1;
      tick(1);
    end
    bus.I_disarm = 1'b1;
    tick(2);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) bus.I_trigger = ~bus.I_trigger;
      bus.I_arm         = ($urandom_range(0, 5) == 0);
      bus.I_disarm      = ($urandom_range(0, 60) == 0);
      bus.I_count_clear = ($urandom_range(0, 80) == 0);
      rst               = ($urandom_range(0, 400) == 0);
      if ($urandom_range(0, 10) == 0) begin
        setup(int'($urandom_range(0, 5)), int'($urandom_range(0, 4)), int'($urandom_range(0, 6)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      tick(1);
    end
    rst = 1'b0;
    tick(3);
    #1;
    check("sb_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
